// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: owner encoding,
// default bus widths and small helpers used by the arbiter and its
// next-state logic.
`timescale 1ns/1ps
package mem_arb_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_t;

  // Burst counter width; a MAX_BURST of 1 still needs a 1-bit counter.
  function automatic int bcnt_width(input int max_burst);
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

  // One-hot {p1,p0} grant for an owner value.
  function automatic logic [1:0] owner_grant(input owner_t o);
    case (o)
      OWN_P0:  return 2'b01;
      OWN_P1:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the
// system memory. The arbiter sits on the slave modport; the masters and
// the memory model together form the master side.
`timescale 1ns/1ps
interface mem_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
);

  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic [1:0]    grant;
  logic          read;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] memoryIn;
  logic [DW-1:0] memoryOut;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  memoryOut,
    output ack0, rdata0, ack1, rdata1,
    output grant, read, write, address, memoryIn
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output memoryOut,
    input  ack0, rdata0, ack1, rdata1,
    input  grant, read, write, address, memoryIn
  );

endinterface

// File: rtl/mem_arb_next.sv
// Combinational next-owner, burst-count and last-served logic for the
// round-robin arbiter with a bounded burst lock.
`timescale 1ns/1ps
module mem_arb_next
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int BW        = bcnt_width(MAX_BURST)
) (
  input  owner_t        owner,
  input  logic          last,
  input  logic [BW-1:0] bcnt,
  input  logic          req0,
  input  logic          req1,
  output owner_t        owner_nx,
  output logic          last_nx,
  output logic [BW-1:0] bcnt_nx
);

  localparam logic [BW-1:0] BCNT_MAX = BW'(MAX_BURST - 1);

  logic [BW-1:0] bcnt_inc;

  assign bcnt_inc = (bcnt == BCNT_MAX) ? bcnt : bcnt + 1'b1;

  // Decide who owns the memory next cycle and how long it has held it.
  always_comb begin
    owner_nx = owner;
    last_nx  = last;
    bcnt_nx  = bcnt;

    // The port that completed an access this cycle becomes "last served";
    // the tie-break below must see this cycle's access, not the stale one.
    if ((owner == OWN_P0) && req0) begin
      last_nx = 1'b0;
    end else if ((owner == OWN_P1) && req1) begin
      last_nx = 1'b1;
    end

    case ({req1, req0})
      2'b00: begin
        owner_nx = OWN_NONE;
        bcnt_nx  = '0;
      end
      2'b01: begin
        owner_nx = OWN_P0;
        bcnt_nx  = (owner == OWN_P0) ? bcnt_inc : '0;
      end
      2'b10: begin
        owner_nx = OWN_P1;
        bcnt_nx  = (owner == OWN_P1) ? bcnt_inc : '0;
      end
      default: begin
        if ((owner != OWN_NONE) && (bcnt != BCNT_MAX)) begin
          bcnt_nx = bcnt + 1'b1;
        end else begin
          owner_nx = last_nx ? OWN_P0 : OWN_P1;
          bcnt_nx  = '0;
        end
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous-write / combinational-read
// memory between the CPU (port 0) and a second master (port 1).
// Ownership is registered; the memory strobes and acks are decoded
// combinationally from the owner so an abandoned request never strobes
// and an asynchronous clear drops the strobes at once.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          clr,
  mem_arbiter_if.slave  bus
);

  localparam int BW = bcnt_width(MAX_BURST);

  owner_t        owner;
  owner_t        owner_nx;
  logic          last;
  logic          last_nx;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_nx;
  logic          acc0;
  logic          acc1;

  mem_arb_next #(
    .MAX_BURST (MAX_BURST),
    .BW        (BW)
  ) u_next (
    .owner    (owner),
    .last     (last),
    .bcnt     (bcnt),
    .req0     (bus.req0),
    .req1     (bus.req1),
    .owner_nx (owner_nx),
    .last_nx  (last_nx),
    .bcnt_nx  (bcnt_nx)
  );

  // Arbitration state; last resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      owner <= OWN_NONE;
      last  <= 1'b1;
      bcnt  <= '0;
    end else begin
      owner <= owner_nx;
      last  <= last_nx;
      bcnt  <= bcnt_nx;
    end
  end

  // Route the owning port to the memory when it is still requesting.
  always_comb begin
    acc0         = (owner == OWN_P0) && bus.req0;
    acc1         = (owner == OWN_P1) && bus.req1;
    bus.grant    = owner_grant(owner);
    bus.read     = 1'b0;
    bus.write    = 1'b0;
    bus.address  = '0;
    bus.memoryIn = '0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    bus.rdata0   = '0;
    bus.rdata1   = '0;
    if (acc0) begin
      bus.read     = ~bus.we0;
      bus.write    = bus.we0;
      bus.address  = bus.addr0;
      bus.memoryIn = bus.wdata0;
      bus.ack0     = 1'b1;
      bus.rdata0   = bus.memoryOut;
    end else if (acc1) begin
      bus.read     = ~bus.we1;
      bus.write    = bus.we1;
      bus.address  = bus.addr1;
      bus.memoryIn = bus.wdata1;
      bus.ack1     = 1'b1;
      bus.rdata1   = bus.memoryOut;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a MAX_BURST=4 instance with a memory model, plus
// a MAX_BURST=1 instance fed the same requests whose grants are watched.
// A reference model of the arbitration rules predicts every cycle.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int MB    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    int own;   // -1 idle, 0 port 0, 1 port 1
    int last;  // last served port
    int run;   // consecutive cycles held beyond the first
  } arb_st_t;

  logic clk = 1'b0;
  logic clr;
  logic preload;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus_b ();

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(1)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (bus_b)
  );

  logic [DW-1:0] mem    [DEPTH];
  logic [DW-1:0] refmem [DEPTH];

  function automatic logic [DW-1:0] pre_val(input int i);
    return 8'hC0 | 8'(i);
  endfunction

  function automatic logic [DW-1:0] fill_val(input int i);
    return (i == 7) ? 8'h06 : 8'(i * 29 + 1);
  endfunction

  // Memory model: synchronous write, combinational read.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre_val(i);
    end else if (bus.write) begin
      mem[bus.address] <= bus.memoryIn;
    end
  end
  assign bus.memoryOut = mem[bus.address];

  assign bus_b.req0      = bus.req0;
  assign bus_b.we0       = bus.we0;
  assign bus_b.addr0     = bus.addr0;
  assign bus_b.wdata0    = bus.wdata0;
  assign bus_b.req1      = bus.req1;
  assign bus_b.we1       = bus.we1;
  assign bus_b.addr1     = bus.addr1;
  assign bus_b.wdata1    = bus.wdata1;
  assign bus_b.memoryOut = '0;

  arb_st_t       s;
  arb_st_t       sb;
  logic          m_ack0, m_ack1;
  logic [1:0]    obs_grant;
  logic          obs_ack0, obs_ack1, obs_read, obs_write;
  logic [DW-1:0] obs_rd0, obs_rd1;

  function automatic arb_st_t st_reset();
    arb_st_t r;
    r.own  = -1;
    r.last = 1;
    r.run  = 0;
    return r;
  endfunction

  function automatic logic [1:0] exp_grant(input int own);
    if (own == 0) return 2'b01;
    if (own == 1) return 2'b10;
    return 2'b00;
  endfunction

  // Arbitration rules stated over port indices and run lengths.
  function automatic arb_st_t next_st(input arb_st_t c, input logic r0, input logic r1, input int mb);
    arb_st_t n;
    logic    r [2];
    int      p;
    n    = c;
    r[0] = r0;
    r[1] = r1;
    if (c.own >= 0 && r[c.own]) n.last = c.own;
    if (!r0 && !r1) begin
      n.own = -1;
      n.run = 0;
    end else if (r0 != r1) begin
      p     = r1 ? 1 : 0;
      n.run = (c.own == p) ? ((c.run + 1 < mb) ? c.run + 1 : mb - 1) : 0;
      n.own = p;
    end else if (c.own >= 0 && c.run < mb - 1) begin
      n.run = c.run + 1;
    end else begin
      n.own = 1 - n.last;
      n.run = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: inputs were set at the preceding negedge.
  task automatic cycle(input string tag);
    logic [1:0]    eg;
    logic          ea0, ea1, er, ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, erd0, erd1;
    logic [33:0]   ev, ov;
    #1;
    eg = exp_grant(s.own);
    ea0 = 1'b0; ea1 = 1'b0; er = 1'b0; ew = 1'b0;
    ea = '0; ed = '0; erd0 = '0; erd1 = '0;
    if (s.own == 0 && bus.req0) begin
      ea0 = 1'b1; ea = bus.addr0; ed = bus.wdata0; ew = bus.we0; er = !bus.we0;
      erd0 = refmem[bus.addr0];
    end else if (s.own == 1 && bus.req1) begin
      ea1 = 1'b1; ea = bus.addr1; ed = bus.wdata1; ew = bus.we1; er = !bus.we1;
      erd1 = refmem[bus.addr1];
    end
    ev = {eg, ea1, ea0, er, ew, ea, ed, erd1, erd0};
    ov = {bus.grant, bus.ack1, bus.ack0, bus.read, bus.write, bus.address,
          bus.memoryIn, bus.rdata1, bus.rdata0};
    chk(tag, 64'(ov), 64'(ev));
    chk({tag, "_b"}, 64'(bus_b.grant), 64'(exp_grant(sb.own)));
    obs_grant = bus.grant; obs_ack0 = bus.ack0; obs_ack1 = bus.ack1;
    obs_read = bus.read; obs_write = bus.write;
    obs_rd0 = bus.rdata0; obs_rd1 = bus.rdata1;
    m_ack0 = ea0;
    m_ack1 = ea1;
    @(posedge clk);
    if (ew) refmem[ea] = ed;
    s  = next_st(s, bus.req0, bus.req1, MB);
    sb = next_st(sb, bus.req0, bus.req1, 1);
    @(negedge clk);
  endtask

  task automatic new_req0();
    bus.we0    = 1'($urandom_range(0, 1));
    bus.addr0  = AW'($urandom_range(0, DEPTH - 1));
    bus.wdata0 = DW'($urandom);
  endtask

  task automatic new_req1();
    bus.we1    = 1'($urandom_range(0, 1));
    bus.addr1  = AW'($urandom_range(0, DEPTH - 1));
    bus.wdata1 = DW'($urandom);
  endtask

  // Port 0 access held until acknowledged (bounded).
  task automatic p0_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input string tag, output int n);
    n = 0;
    bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    do begin
      cycle(tag);
      n++;
    end while (!m_ack0 && n < 20);
    chk({tag, "_ack"}, 64'(obs_ack0), 64'(1));
  endtask

  task automatic do_reset();
    clr = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    s  = st_reset();
    sb = st_reset();
  endtask

  initial begin
    int n;
    int nack;
    clr = 1'b1; preload = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    s = st_reset(); sb = st_reset();
    m_ack0 = 1'b0; m_ack1 = 1'b0;
    for (int i = 0; i < DEPTH; i++) refmem[i] = pre_val(i);

    // Reset state
    #12;
    chk("rst_out", 64'({bus.grant, bus.ack1, bus.ack0, bus.read, bus.write, bus.address,
                        bus.memoryIn, bus.rdata1, bus.rdata0}), 64'(0));
    chk("rst_grant_b", 64'(bus_b.grant), 64'(0));
    @(negedge clk);
    preload = 1'b0;
    clr = 1'b0;
    repeat (3) cycle("idle");
    chk("idle_grant", 64'(obs_grant), 64'(0));

    // Single write then read on port 0
    p0_access(1'b1, 4'd3, 8'hA5, "wr3", n);
    chk("wr3_latency", 64'(n), 64'(2));
    chk("wr3_mem", 64'(mem[3]), 64'(8'hA5));
    p0_access(1'b0, 4'd3, 8'h00, "rd3", n);
    chk("rd3_latency", 64'(n), 64'(1));
    chk("rd3_data", 64'(obs_rd0), 64'(8'hA5));
    bus.req0 = 1'b0;
    cycle("idle");

    // Fill memory through port 0
    for (int i = 0; i < DEPTH; i++) p0_access(1'b1, AW'(i), fill_val(i), "fill", n);
    bus.req0 = 1'b0;
    cycle("idle");
    for (int i = 0; i < DEPTH; i++) chk("fill_mem", 64'(mem[i]), 64'(fill_val(i)));

    // Abandoned request
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd5; bus.wdata0 = 8'hFF;
    cycle("ab0");
    bus.req0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd9; bus.wdata1 = 8'h00;
    cycle("ab1");
    chk("ab_grant", 64'(obs_grant), 64'(2'b01));
    chk("ab_nostrobe", 64'({obs_write, obs_read, obs_ack0, obs_ack1}), 64'(0));
    cycle("ab2");
    chk("ab_ack1", 64'(obs_ack1), 64'(1));
    chk("ab_rd1", 64'(obs_rd1), 64'(fill_val(9)));
    bus.req1 = 1'b0;
    cycle("idle");
    chk("ab_mem5", 64'(mem[5]), 64'(fill_val(5)));

    // Lone requester on port 1
    bus.req1 = 1'b1;
    new_req1();
    nack = 0;
    for (int c = 0; c < 11; c++) begin
      cycle("lone");
      if (obs_ack1) nack++;
      if (m_ack1) new_req1();
    end
    chk("lone_acks", 64'(nack), 64'(10));
    bus.req1 = 1'b0;
    cycle("idle");

    // Contention from reset
    do_reset();
    bus.req0 = 1'b1; new_req0();
    bus.req1 = 1'b1; new_req1();
    for (int c = 0; c < 17; c++) begin
      cycle("cont");
      chk("cont_pat", 64'(obs_grant),
          64'((c == 0) ? 2'b00 : ((((c - 1) / 4) % 2) != 0 ? 2'b10 : 2'b01)));
      chk("cont_pat_b", 64'(bus_b.grant),
          64'((c == 0) ? 2'b01 : (((c % 2) != 0) ? 2'b10 : 2'b01)));
      if (m_ack0) new_req0();
      if (m_ack1) new_req1();
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cycle("idle");

    // Reset in the middle of a write access
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd7; bus.wdata0 = 8'h3C;
    cycle("rb0");
    #1;
    chk("rb_w_on", 64'({bus.write, bus.address}), 64'({1'b1, 4'd7}));
    #1 clr = 1'b1;
    #1;
    chk("rb_w_off", 64'({bus.write, bus.ack0, bus.grant}), 64'(0));
    bus.req0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rb_mem7", 64'(mem[7]), 64'(8'h06));
    clr = 1'b0;
    s = st_reset(); sb = st_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd7;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'd2;
    cycle("rb1");
    cycle("rb2");
    chk("rb_first", 64'(obs_grant), 64'(2'b01));
    chk("rb_rd7", 64'(obs_rd0), 64'(8'h06));
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cycle("idle");

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      if (!bus.req0 && $urandom_range(0, 3) != 0) begin bus.req0 = 1'b1; new_req0(); end
      if (!bus.req1 && $urandom_range(0, 3) != 0) begin bus.req1 = 1'b1; new_req1(); end
      cycle("rand");
      if (m_ack0) begin
        bus.req0 = 1'b0;
        if ($urandom_range(0, 1) != 0) begin bus.req0 = 1'b1; new_req0(); end
      end
      if (m_ack1) begin
        bus.req1 = 1'b0;
        if ($urandom_range(0, 1) != 0) begin bus.req1 = 1'b1; new_req1(); end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    cycle("idle");
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 64'(mem[i]), 64'(refmem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
